// File: rtl/reflet_bus_arbiter_pkg.sv
// Shared types and helpers for the reflet memory-bus arbiter.
package reflet_bus_arbiter_pkg;

   localparam int ARB_OWNER_W = 2;

   typedef enum logic {
      ARB_IDLE  = 1'b0,
      ARB_OWNED = 1'b1
   } arb_state_e;

   // Index of the master after idx, wrapping at n.
   function automatic logic [ARB_OWNER_W-1:0] rr_next(input logic [ARB_OWNER_W-1:0] idx,
                                                      input int n);
      int nxt;
      nxt = int'(idx) + 1;
      if (nxt >= n) nxt = 0;
      return ARB_OWNER_W'(nxt);
   endfunction

endpackage

// File: rtl/reflet_bus_arbiter_rr_pick.sv
// Combinational round-robin pick: first requester at or after ptr_i (wrapping),
// optionally skipping one excluded index.
module reflet_bus_arbiter_rr_pick
   import reflet_bus_arbiter_pkg::*;
#(
   parameter int masters = 2
) (
   input  logic [masters-1:0]     req_i,
   input  logic [ARB_OWNER_W-1:0] ptr_i,
   input  logic                   excl_en_i,
   input  logic [ARB_OWNER_W-1:0] excl_i,
   output logic                   found_o,
   output logic [ARB_OWNER_W-1:0] idx_o
);

   always_comb begin
      int                 cand;
      logic [masters-1:0] cand_oh;
      found_o = 1'b0;
      idx_o   = '0;
      cand    = 0;
      cand_oh = '0;
      for (int k = 0; k < masters; k++) begin
         cand    = (int'(ptr_i) + k) % masters;
         cand_oh = masters'(1) << cand;
         if (!found_o && |(req_i & cand_oh) &&
             !(excl_en_i && excl_i == ARB_OWNER_W'(cand))) begin
            found_o = 1'b1;
            idx_o   = ARB_OWNER_W'(cand);
         end
      end
   end

endmodule

// File: rtl/reflet_bus_arbiter.sv
// Round-robin arbiter sharing one memory bus between several reflet masters,
// with a bounded burst length while others are waiting.
//
// state     | meaning
// ARB_IDLE  | no owner; bus driven to zero
// ARB_OWNED | owner's address/data/strobe muxed onto the bus
module reflet_bus_arbiter
   import reflet_bus_arbiter_pkg::*;
#(
   parameter int wordsize  = 16,
   parameter int masters   = 2,
   parameter int max_burst = 8
) (
   input  logic                        clk,
   input  logic                        reset,
   input  logic                        enable,
   input  logic [masters-1:0]          m_req,
   input  logic [masters*wordsize-1:0] m_addr,
   input  logic [masters*wordsize-1:0] m_data_out,
   input  logic [masters-1:0]          m_write_en,
   output logic [masters-1:0]          m_grant,
   output logic [masters-1:0]          m_enable,
   output logic [wordsize-1:0]         m_data_in,
   output logic [wordsize-1:0]         addr,
   output logic [wordsize-1:0]         data_out,
   output logic                        write_en,
   input  logic [wordsize-1:0]         data_in,
   output logic [ARB_OWNER_W-1:0]      owner,
   output logic                        busy
);

   localparam int BW = (max_burst > 1) ? $clog2(max_burst) : 1;

   arb_state_e             state_q;
   logic [masters-1:0]     grant_q;
   logic [ARB_OWNER_W-1:0] owner_q;
   logic [ARB_OWNER_W-1:0] rr_ptr_q;
   logic [BW-1:0]          burst_q;
   logic                   busy_q;

   logic                   owned;
   logic                   owner_req;
   logic                   burst_last;
   logic [ARB_OWNER_W-1:0] owner_next;
   logic [ARB_OWNER_W-1:0] pick_ptr;
   logic                   pick_found;
   logic [ARB_OWNER_W-1:0] pick_idx;
   logic [masters-1:0]     pick_oh;

   assign owned      = (state_q == ARB_OWNED);
   assign owner_req  = |(m_req & grant_q);
   assign burst_last = (burst_q == BW'(max_burst - 1));
   assign owner_next = rr_next(owner_q, masters);
   // While owned, the same picker finds the next contender after the owner.
   assign pick_ptr   = owned ? owner_next : rr_ptr_q;

   reflet_bus_arbiter_rr_pick #(.masters(masters)) u_pick (
      .req_i     (m_req),
      .ptr_i     (pick_ptr),
      .excl_en_i (owned),
      .excl_i    (owner_q),
      .found_o   (pick_found),
      .idx_o     (pick_idx)
   );

   always_comb begin
      pick_oh = '0;
      for (int i = 0; i < masters; i++) pick_oh[i] = (pick_idx == ARB_OWNER_W'(i));
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q  <= ARB_IDLE;
         grant_q  <= '0;
         owner_q  <= '0;
         rr_ptr_q <= '0;
         burst_q  <= '0;
         busy_q   <= 1'b0;
      end else if (enable) begin
         case (state_q)
            ARB_IDLE: begin
               if (pick_found) begin
                  state_q <= ARB_OWNED;
                  grant_q <= pick_oh;
                  owner_q <= pick_idx;
                  busy_q  <= 1'b1;
                  burst_q <= '0;
               end
            end
            ARB_OWNED: begin
               if (!owner_req) begin
                  rr_ptr_q <= owner_next;
                  if (pick_found) begin
                     grant_q <= pick_oh;
                     owner_q <= pick_idx;
                     burst_q <= '0;
                  end else begin
                     state_q <= ARB_IDLE;
                     grant_q <= '0;
                     busy_q  <= 1'b0;
                  end
               end else if (pick_found && burst_last) begin
                  rr_ptr_q <= owner_next;
                  grant_q  <= pick_oh;
                  owner_q  <= pick_idx;
                  burst_q  <= '0;
               end else if (!burst_last) begin
                  burst_q <= burst_q + 1'b1;
               end
            end
            default: begin
               state_q <= ARB_IDLE;
               grant_q <= '0;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

   // Grant is one-hot, so at most one master's signals pass the mux.
   always_comb begin
      addr     = '0;
      data_out = '0;
      write_en = 1'b0;
      for (int i = 0; i < masters; i++) begin
         if (grant_q[i]) begin
            addr     = m_addr[i*wordsize +: wordsize];
            data_out = m_data_out[i*wordsize +: wordsize];
            write_en = m_write_en[i] & enable;
         end
      end
   end

   assign m_grant   = grant_q;
   assign m_enable  = grant_q & {masters{enable}};
   assign m_data_in = data_in;
   assign owner     = owner_q;
   assign busy      = busy_q;

endmodule

// File: tb/tb_reflet_bus_arbiter.sv
// Scoreboard bench for reflet_bus_arbiter: a rule-level reference model pushes
// expected outputs per cycle, a monitor pops and compares them.
module tb_reflet_bus_arbiter;

   localparam int W  = 16;
   localparam int M  = 2;
   localparam int MB = 8;

   logic           clk = 1'b0;
   logic           reset;
   logic           enable;
   logic [M-1:0]   m_req;
   logic [M*W-1:0] m_addr;
   logic [M*W-1:0] m_data_out;
   logic [M-1:0]   m_write_en;
   logic [M-1:0]   m_grant;
   logic [M-1:0]   m_enable;
   logic [W-1:0]   m_data_in;
   logic [W-1:0]   addr;
   logic [W-1:0]   data_out;
   logic           write_en;
   logic [W-1:0]   data_in;
   logic [1:0]     owner;
   logic           busy;

   always #5 clk = ~clk;

   reflet_bus_arbiter #(.wordsize(W), .masters(M), .max_burst(MB)) dut (
      .clk        (clk),
      .reset      (reset),
      .enable     (enable),
      .m_req      (m_req),
      .m_addr     (m_addr),
      .m_data_out (m_data_out),
      .m_write_en (m_write_en),
      .m_grant    (m_grant),
      .m_enable   (m_enable),
      .m_data_in  (m_data_in),
      .addr       (addr),
      .data_out   (data_out),
      .write_en   (write_en),
      .data_in    (data_in),
      .owner      (owner),
      .busy       (busy)
   );

   typedef struct {
      logic [M-1:0] grant;
      logic [M-1:0] men;
      logic [W-1:0] addr;
      logic [W-1:0] dout;
      logic [W-1:0] din;
      logic         we;
      logic         busy;
      logic [1:0]   owner;
   } exp_t;

   exp_t sb_q[$];
   int   checks = 0;
   int   errors = 0;

   // Reference model state: who owns the bus and how long they have held it.
   int mo_busy, mo_owner, mo_rr, mo_burst;
   bit push_en = 1'b0;
   bit fix_m1  = 1'b0;

   function automatic int find_from(input logic [M-1:0] req, input int start, input int excl);
      for (int k = 0; k < M; k++) begin
         int i;
         i = (start + k) % M;
         if (i != excl && req[i]) return i;
      end
      return -1;
   endfunction

   task automatic model_step(input bit rst, input bit en, input logic [M-1:0] req);
      int n;
      if (!rst) begin
         mo_busy = 0; mo_owner = 0; mo_rr = 0; mo_burst = 0;
      end else if (en) begin
         if (mo_busy == 0) begin
            n = find_from(req, mo_rr, -1);
            if (n >= 0) begin
               mo_busy = 1; mo_owner = n; mo_burst = 0;
            end
         end else begin
            n = find_from(req, (mo_owner + 1) % M, mo_owner);
            if (!req[mo_owner]) begin
               mo_rr = (mo_owner + 1) % M;
               if (n >= 0) begin
                  mo_owner = n; mo_burst = 0;
               end else begin
                  mo_busy = 0;
               end
            end else if (n >= 0 && mo_burst == MB - 1) begin
               mo_rr = (mo_owner + 1) % M;
               mo_owner = n; mo_burst = 0;
            end else if (mo_burst < MB - 1) begin
               mo_burst++;
            end
         end
      end
   endtask

   task automatic drive(input bit rst, input bit en, input logic [M-1:0] req,
                        input logic [M-1:0] we);
      exp_t e;
      @(negedge clk);
      reset = rst; enable = en; m_req = req; m_write_en = we;
      for (int i = 0; i < M; i++) begin
         m_addr[i*W +: W]     = W'($urandom);
         m_data_out[i*W +: W] = W'($urandom);
      end
      if (fix_m1) begin
         m_addr[W +: W]     = 16'h0040;
         m_data_out[W +: W] = 16'hBEEF;
      end
      data_in = W'($urandom);
      if (push_en) begin
         e.grant = (mo_busy != 0) ? (M'(1) << mo_owner) : '0;
         e.men   = en ? e.grant : '0;
         e.addr  = (mo_busy != 0) ? m_addr[mo_owner*W +: W] : '0;
         e.dout  = (mo_busy != 0) ? m_data_out[mo_owner*W +: W] : '0;
         e.we    = (mo_busy != 0) && en && we[mo_owner];
         e.din   = data_in;
         e.busy  = (mo_busy != 0);
         e.owner = 2'(mo_owner);
         sb_q.push_back(e);
      end
      model_step(rst, en, req);
   endtask

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         #2;
         if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            chk("m_grant",   32'(m_grant),   32'(e.grant));
            chk("m_enable",  32'(m_enable),  32'(e.men));
            chk("busy",      32'(busy),      32'(e.busy));
            chk("addr",      32'(addr),      32'(e.addr));
            chk("data_out",  32'(data_out),  32'(e.dout));
            chk("write_en",  32'(write_en),  32'(e.we));
            chk("m_data_in", 32'(m_data_in), 32'(e.din));
            if (e.busy) chk("owner", 32'(owner), 32'(e.owner));
         end
      end
   end

   initial begin
      logic [M-1:0] r;
      reset = 1'b0; enable = 1'b1; m_req = '0; m_addr = '0; m_data_out = '0;
      m_write_en = '0; data_in = '0;

      // Reset while both request, then release: master 0 wins first.
      repeat (3) drive(1'b0, 1'b1, 2'b11, 2'b00);
      push_en = 1'b1;
      drive(1'b0, 1'b1, 2'b11, 2'b00);
      repeat (3) drive(1'b1, 1'b1, 2'b11, 2'b00);

      // Master 0 alone: no preemption.
      repeat (2) drive(1'b1, 1'b1, 2'b00, 2'b00);
      repeat (20) drive(1'b1, 1'b1, 2'b01, M'($urandom));

      // Both continuously: alternating bursts of MB.
      repeat (2) drive(1'b1, 1'b1, 2'b00, 2'b00);
      repeat (40) drive(1'b1, 1'b1, 2'b11, 2'b00);

      // Master 1 waits with a pending write while master 0 owns the bus.
      repeat (2) drive(1'b1, 1'b1, 2'b00, 2'b00);
      repeat (3) drive(1'b1, 1'b1, 2'b01, 2'b00);
      fix_m1 = 1'b1;
      repeat (12) drive(1'b1, 1'b1, 2'b11, 2'b10);
      fix_m1 = 1'b0;

      // Owner 0 releases while master 1 waits: zero dead cycles.
      repeat (2) drive(1'b1, 1'b1, 2'b00, 2'b00);
      repeat (2) drive(1'b1, 1'b1, 2'b01, 2'b00);
      repeat (2) drive(1'b1, 1'b1, 2'b11, 2'b00);
      repeat (3) drive(1'b1, 1'b1, 2'b10, 2'b10);

      // Reset mid-burst with master 1 owning.
      repeat (2) drive(1'b1, 1'b1, 2'b00, 2'b00);
      repeat (5) drive(1'b1, 1'b1, 2'b10, 2'b10);
      drive(1'b0, 1'b1, 2'b11, 2'b11);
      repeat (3) drive(1'b1, 1'b1, 2'b11, 2'b11);

      // Enable toggling while both request.
      for (int c = 0; c < 30; c++) drive(1'b1, 1'(c % 3 != 0), 2'b11, M'($urandom));

      // Random traffic.
      r = '0;
      for (int c = 0; c < 3000; c++) begin
         for (int i = 0; i < M; i++) if ($urandom_range(7) == 0) r[i] = ~r[i];
         drive(1'($urandom_range(199) != 0), 1'($urandom_range(9) != 0), r, M'($urandom));
      end

      @(negedge clk);
      #4;
      chk("scoreboard_drained", 32'(sb_q.size()), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/reflet_bus_arbiter.md
Name: reflet_bus_arbiter

Overview:
- Shares one system memory bus (addr, data_out, data_in, write_en) between up to `masters` bus masters, e.g. two reflet_cpu cores, or a CPU plus a DMA/peripheral engine.
- Round-robin grant with a bounded burst length.
- Each master is stalled through its own enable output while it is not the bus owner.
- Sits between the masters and the RAM/peripheral address decoder.

Parameters:
- wordsize, 16, bus word width; must match the attached reflet_cpu wordsize.
- masters, 2, number of requesters (2..4).
- max_burst, 8, maximum consecutive owned cycles while another master is requesting (>=1).

Ports:
- clk  input  1  clock.
- reset  input  1  synchronous, active-low reset.
- enable  input  1  global enable; when low, arbiter state freezes and all m_enable outputs are low.
- m_req  input  masters  per-master bus request, held high for the whole transaction.
- m_addr  input  masters*wordsize  flattened per-master address; master i occupies bits [i*wordsize +: wordsize].
- m_data_out  input  masters*wordsize  flattened per-master write data.
- m_write_en  input  masters  per-master write strobe.
- m_grant  output  masters  one-hot (or all-zero) ownership indication, registered.
- m_enable  output  masters  equals enable & m_grant[i]; drives the master's enable input.
- m_data_in  output  wordsize  bus read data, broadcast to all masters.
- addr  output  wordsize  shared bus address.
- data_out  output  wordsize  shared bus write data.
- write_en  output  1  shared bus write strobe.
- data_in  input  wordsize  shared bus read data.
- owner  output  2  index of the current owner; valid only when busy=1.
- busy  output  1  high when any grant is active.

Behaviour:
- Reset (reset=0 at a clk edge):
  - state=IDLE, m_grant=0, owner=0, busy=0, rr_ptr=0, burst_cnt=0.
  - Reset has priority over enable.
  - Reset mid-grant drops the grant on that edge; the master is stalled from the next cycle.
- States:
  - IDLE: no owner. addr=0, data_out=0, write_en=0.
  - OWNED: the owner's m_addr, m_data_out and m_write_en are combinationally muxed onto the bus. Non-owner write strobes never reach the bus.
- Selection (round robin): scan from index rr_ptr upward with wrap-around; pick the first i with m_req[i]=1.
- IDLE -> OWNED:
  - Occurs on the first edge where any m_req is high and enable=1.
  - Grant latency: m_grant rises 1 cycle after m_req is seen.
  - On entry, burst_cnt=0.
- OWNED, owner still requesting, no other request: stay in OWNED. burst_cnt saturates at max_burst-1; no preemption.
- OWNED, owner still requesting, another master requesting, burst_cnt==max_burst-1 (preemption):
  - Hand over on the next edge to the next requester after the owner (round robin).
  - Set rr_ptr=owner+1 mod masters and burst_cnt=0.
- OWNED, owner releases (m_req[owner]=0):
  - Set rr_ptr=owner+1 mod masters.
  - If another master is requesting, hand over to it directly on the same edge (zero dead cycles).
  - Otherwise go to IDLE.
- burst_cnt increments on each enabled OWNED cycle in which the owner is not preempted and does not release.
- enable=0: state, rr_ptr, burst_cnt and m_grant hold; all m_enable=0; bus outputs still follow the owner mux, except write_en is forced to 0.
- m_req for an index >= masters does not exist; the default case selects nothing.
- Handover happens only at clk edges, so a write strobe never spans two owners.

Decomposition:
- Add to reflet.vh:
  - arbiter state encodings: `arb_idle, `arb_owned.
  - owner width constant: `arb_owner_w = 2.
- Sub-module reflet_rr_pick: combinational round-robin pick.
  - Inputs: request vector, rr_ptr, excluded index.
  - Outputs: found flag, chosen index.
  - The arbiter uses it for both idle pick and handover.

Test Plan:
- Reset with m_req=2'b11, then release reset -> cycle 1 after release: m_grant=2'b01, owner=0, busy=1; bus addr equals m_addr[0].
- Master 0 holds req alone for 20 cycles -> grant stays 2'b01 throughout; no preemption; m_enable=2'b01.
- Both masters request continuously, max_burst=8 -> grant alternates 2'b01 for 8 cycles, then 2'b10 for 8, repeating; zero idle cycles between owners.
- Master 1 writes addr=16'h0040, data=16'hBEEF while master 0 owns the bus -> write_en stays 0 and RAM is unchanged until master 1 is granted; then the write appears once.
- Owner 0 drops req while master 1 requests -> next cycle m_grant=2'b10; rr_ptr=1; no IDLE cycle.
- Reset asserted mid-burst (owner=1, burst_cnt=4) -> next cycle m_grant=0, busy=0, write_en=0; after release, master 0 wins first (rr_ptr=0).
